// File: rtl/stage3_fetch_redirect_ctrl_if.sv
// Instruction-memory read bus between the fetch controller (master) and memory (slave).
interface stage3_fetch_redirect_ctrl_if;
  logic        imem_ren;
  logic [31:0] imem_addr;
  logic        imem_busy;
  logic [31:0] imem_rdata;

  modport master (output imem_ren, output imem_addr, input imem_busy, input imem_rdata);
  modport slave  (input imem_ren, input imem_addr, output imem_busy, output imem_rdata);
endinterface

// File: rtl/stage3_fetch_redirect_ctrl.sv
// Fetch PC / instruction-request controller with redirect kill and in-flight drain.
// Optional misaligned-target trapping is enabled by STAGE3_FETCH_MISALIGN_CHECK_EN.
module stage3_fetch_redirect_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0200
) (
  input  logic                         CLK,
  input  logic                         nRST,
  stage3_fetch_redirect_ctrl_if.master imem,
  input  logic                         redirect,
  input  logic [31:0]                  brj_addr,
  input  logic                         ex_stall,
  output logic                         fe_valid,
  output logic [31:0]                  fe_instr,
  output logic [31:0]                  fe_pc,
  output logic [31:0]                  fe_pc4
`ifdef STAGE3_FETCH_MISALIGN_CHECK_EN
  ,
  output logic                         fe_misaligned
`endif
);

  typedef enum logic {S_FETCH, S_DRAIN} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, r_pend;
  logic        r_fe_valid;
  logic [31:0] r_fe_instr, r_fe_pc, r_fe_pc4;
  logic        w_ren, w_full, w_inflight, w_complete, w_consume, w_apply, w_hold;
  logic [31:0] w_tgt;

`ifdef STAGE3_FETCH_MISALIGN_CHECK_EN
  logic r_misaligned;
  logic w_tgt_mis;
  assign w_tgt_mis     = |w_tgt[1:0];
  assign w_hold        = r_misaligned;
  assign fe_misaligned = r_misaligned;
`else
  assign w_hold = 1'b0;
`endif

  assign w_full     = r_fe_valid && ex_stall;
  assign w_inflight = w_ren && imem.imem_busy;
  assign w_complete = (r_state == S_FETCH) && w_ren && !imem.imem_busy && !redirect;
  assign w_consume  = r_fe_valid && !ex_stall;
  // A redirect arriving on the drain's final cycle supersedes the pending target.
  assign w_tgt      = (r_state == S_DRAIN && !redirect) ? r_pend : brj_addr;
  assign w_apply    = (r_state == S_FETCH) ? (redirect && !w_inflight) : !imem.imem_busy;

  always_ff @(posedge CLK) begin
    if (!nRST) r_state <= S_FETCH;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FETCH: if (redirect && w_inflight) w_state_nxt = S_DRAIN;
      S_DRAIN: if (!imem.imem_busy)        w_state_nxt = S_FETCH;
      default: w_state_nxt = S_FETCH;
    endcase
  end

  always_comb begin
    w_ren = 1'b0;
    case (r_state)
      S_FETCH: w_ren = nRST && !w_full && !w_hold;
      S_DRAIN: w_ren = nRST;
      default: w_ren = 1'b0;
    endcase
  end

  assign imem.imem_ren  = w_ren;
  assign imem.imem_addr = r_pc;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_pc       <= RESET_PC;
      r_pend     <= '0;
      r_fe_valid <= 1'b0;
      r_fe_instr <= '0;
      r_fe_pc    <= '0;
      r_fe_pc4   <= '0;
`ifdef STAGE3_FETCH_MISALIGN_CHECK_EN
      r_misaligned <= 1'b0;
`endif
    end else begin
      if (redirect && w_inflight) r_pend <= brj_addr;
      if (w_apply) begin
        r_fe_valid <= 1'b0;
        r_pc       <= w_tgt & 32'hFFFF_FFFC;
`ifdef STAGE3_FETCH_MISALIGN_CHECK_EN
        // Misaligned target: present a NOP-flagged entry instead of fetching.
        r_misaligned <= w_tgt_mis;
        if (w_tgt_mis) begin
          r_fe_valid <= 1'b1;
          r_fe_instr <= 32'h0000_0013;
          r_fe_pc    <= w_tgt;
          r_fe_pc4   <= w_tgt + 32'd4;
        end
`endif
      end else if (redirect || r_state == S_DRAIN) begin
        r_fe_valid <= 1'b0;
      end else if (w_complete) begin
        r_fe_valid <= 1'b1;
        r_fe_instr <= imem.imem_rdata;
        r_fe_pc    <= r_pc;
        r_fe_pc4   <= r_pc + 32'd4;
        r_pc       <= r_pc + 32'd4;
      end else if (w_consume) begin
        r_fe_valid <= 1'b0;
      end
    end
  end

  assign fe_valid = r_fe_valid;
  assign fe_instr = r_fe_instr;
  assign fe_pc    = r_fe_pc;
  assign fe_pc4   = r_fe_pc4;

endmodule
